// File: rtl/load_buf_tracker.sv
// Outstanding dcache load tracker: allocates a tag per accepted load, keeps its
// metadata, and formats the cache response into an aligned, extended result.
module load_buf_tracker #(
  parameter int XLEN       = 32,
  parameter int NR_ENTRIES = 2,
  parameter int TRANS_ID_W = 3,
  parameter int TAG_W      = 1,
  parameter int OFFSET_W   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  kill_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [TRANS_ID_W-1:0] req_trans_id_i,
  input  logic [OFFSET_W-1:0]   req_offset_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_sign_i,
  output logic [TAG_W-1:0]      req_tag_o,
  input  logic                  rsp_valid_i,
  input  logic [TAG_W-1:0]      rsp_tag_i,
  input  logic [XLEN-1:0]       rsp_data_i,
  output logic                  out_valid_o,
  output logic [TRANS_ID_W-1:0] out_trans_id_o,
  output logic [XLEN-1:0]       out_data_o,
  output logic                  busy_o
);

  // Shift the raw word down to the addressed byte, then keep 8/16/XLEN bits and
  // extend. Misaligned halves keep whatever the zero-filled shift produced.
  function automatic logic [XLEN-1:0] format_load(
    input logic [XLEN-1:0]     raw,
    input logic [OFFSET_W-1:0] off,
    input logic [1:0]          size,
    input logic                sign
  );
    logic [XLEN-1:0] shifted;
    logic            ext;
    logic [XLEN-1:0] res;
    shifted = raw >> {off, 3'b000};
    case (size)
      2'd0: begin
        ext = sign & shifted[7];
        res = {{(XLEN-8){ext}}, shifted[7:0]};
      end
      2'd1: begin
        ext = sign & shifted[15];
        res = {{(XLEN-16){ext}}, shifted[15:0]};
      end
      default: res = shifted;
    endcase
    return res;
  endfunction

  logic [NR_ENTRIES-1:0] valid_q;
  logic [NR_ENTRIES-1:0] killed_q;
  logic [NR_ENTRIES-1:0] sign_q;
  logic [TRANS_ID_W-1:0] trans_id_q [NR_ENTRIES];
  logic [OFFSET_W-1:0]   offset_q   [NR_ENTRIES];
  logic [1:0]            size_q     [NR_ENTRIES];

  logic                  free_any;
  logic [TAG_W-1:0]      free_tag;
  logic                  accept;
  logic                  rsp_in_range;
  logic                  rsp_hit;
  logic                  vld_p0;
  logic [XLEN-1:0]       data_p0;
  logic                  vld_p1;
  logic [TRANS_ID_W-1:0] trans_id_p1;
  logic [XLEN-1:0]       data_p1;

  // Descending scan so the lowest free index is the one left in free_tag.
  always_comb begin
    free_any = 1'b0;
    free_tag = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
  end

  assign req_ready_o = !kill_i && free_any;
  assign req_tag_o   = free_tag;
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = |valid_q;

  generate
    if ((2 ** TAG_W) > NR_ENTRIES) begin : g_tag_sparse
      assign rsp_in_range = (int'(rsp_tag_i) < NR_ENTRIES);
    end else begin : g_tag_dense
      assign rsp_in_range = 1'b1;
    end
  endgenerate

  // Stage p0: response arrives; a killed entry or a concurrent flush drops it.
  assign rsp_hit = rsp_valid_i && rsp_in_range && valid_q[rsp_tag_i];
  assign vld_p0  = rsp_hit && !killed_q[rsp_tag_i] && !kill_i;
  assign data_p0 = format_load(rsp_data_i, offset_q[rsp_tag_i],
                               size_q[rsp_tag_i], sign_q[rsp_tag_i]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      killed_q <= '0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (accept && (free_tag == TAG_W'(i))) begin
          valid_q[i]  <= 1'b1;
          killed_q[i] <= 1'b0;
        end else if (rsp_hit && (rsp_tag_i == TAG_W'(i))) begin
          valid_q[i]  <= 1'b0;
          killed_q[i] <= 1'b0;
        end else if (kill_i && valid_q[i]) begin
          killed_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (accept && (free_tag == TAG_W'(i))) begin
        trans_id_q[i] <= req_trans_id_i;
        offset_q[i]   <= req_offset_i;
        size_q[i]     <= req_size_i;
        sign_q[i]     <= req_sign_i;
      end
    end
  end

  // Stage p1: registered result, valid for exactly one cycle per response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1      <= 1'b0;
      trans_id_p1 <= '0;
      data_p1     <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        trans_id_p1 <= trans_id_q[rsp_tag_i];
        data_p1     <= data_p0;
      end
    end
  end

  assign out_valid_o    = vld_p1;
  assign out_trans_id_o = trans_id_p1;
  assign out_data_o     = data_p1;

endmodule

// File: tb/tb_load_buf_tracker.sv
// Scoreboard bench for load_buf_tracker: expected results are queued at response
// time and matched (ID, data, arrival cycle) when out_valid_o fires.
module tb_load_buf_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_trans = '0;
  logic [1:0]  req_off = '0;
  logic [1:0]  req_size = '0;
  logic        req_sign = 1'b0;
  logic [0:0]  req_tag;
  logic        rsp_valid = 1'b0;
  logic [0:0]  rsp_tag = '0;
  logic [31:0] rsp_data = '0;
  logic        out_valid;
  logic [2:0]  out_trans;
  logic [31:0] out_data;
  logic        busy;

  load_buf_tracker dut (
    .clk_i(clk), .rst_ni(rst_n), .kill_i(kill),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_trans_id_i(req_trans), .req_offset_i(req_off),
    .req_size_i(req_size), .req_sign_i(req_sign), .req_tag_o(req_tag),
    .rsp_valid_i(rsp_valid), .rsp_tag_i(rsp_tag), .rsp_data_i(rsp_data),
    .out_valid_o(out_valid), .out_trans_id_o(out_trans), .out_data_o(out_data),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  trans;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;

  bit         m_valid [2];
  bit         m_kill  [2];
  logic [2:0] m_trans [2];
  logic [1:0] m_off   [2];
  logic [1:0] m_size  [2];
  bit         m_sign  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt_ref(logic [31:0] d, logic [1:0] off,
                                          logic [1:0] sz, bit sg);
    logic [31:0] sh;
    logic [31:0] r;
    int w;
    sh = d >> (8 * off);
    w = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    r = sh;
    for (int b = 0; b < 32; b++)
      if (b >= w) r[b] = sg & sh[w-1];
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      check("out_expected", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_trans", out_trans, mon_e.trans);
        check("out_data", out_data, mon_e.data);
        check("out_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic send_req(input logic [2:0] t, input logic [1:0] off, input logic [1:0] sz,
                          input bit sg, input int exp_tag);
    int n = 0;
    req_valid = 1'b1; req_trans = t; req_off = off; req_size = sz; req_sign = sg;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("req_ready_wait", req_ready, 1);
    check("req_tag", req_tag, exp_tag);
    if (req_ready) begin
      m_valid[exp_tag] = 1; m_kill[exp_tag] = 0; m_trans[exp_tag] = t;
      m_off[exp_tag] = off; m_size[exp_tag] = sz; m_sign[exp_tag] = sg;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send_rsp(input int tag, input logic [31:0] d,
                          input bit use_ov, input logic [31:0] ov);
    exp_t e;
    rsp_valid = 1'b1; rsp_tag = tag[0:0]; rsp_data = d;
    if (m_valid[tag]) begin
      if (!m_kill[tag] && !kill) begin
        e.trans = m_trans[tag];
        e.data  = use_ov ? ov : fmt_ref(d, m_off[tag], m_size[tag], m_sign[tag]);
        e.cyc   = cyc + 1;
        sb.push_back(e);
      end
      m_valid[tag] = 0; m_kill[tag] = 0;
    end
    if (kill) for (int i = 0; i < 2; i++) if (m_valid[i]) m_kill[i] = 1;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic pulse_kill();
    kill = 1'b1;
    for (int i = 0; i < 2; i++) if (m_valid[i]) m_kill[i] = 1;
    @(negedge clk);
    kill = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin m_valid[i] = 0; m_kill[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_trans", out_trans, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill both slots, stall a third request, free a slot, retry
    send_req(3'd5, 2'd0, 2'd2, 0, 0);
    send_req(3'd3, 2'd0, 2'd2, 0, 1);
    #1;
    check("full_ready", req_ready, 0);
    check("full_busy", busy, 1);
    req_valid = 1'b1; req_trans = 3'd6; req_off = 2'd0; req_size = 2'd2; req_sign = 1'b0;
    check("stall_ready", req_ready, 0);
    send_rsp(0, 32'h11223344, 0, 0);
    #1;
    check("freed_ready", req_ready, 1);
    check("freed_tag", req_tag, 0);
    m_valid[0] = 1; m_kill[0] = 0; m_trans[0] = 3'd6;
    m_off[0] = 2'd0; m_size[0] = 2'd2; m_sign[0] = 0;
    @(negedge clk);
    req_valid = 1'b0;

    // Out-of-order, back-to-back responses
    send_rsp(1, 32'hCAFEF00D, 0, 0);
    send_rsp(0, 32'h0BADBEEF, 0, 0);
    #1;
    check("drain_busy", busy, 0);

    // Formatting with fixed expected values
    send_req(3'd1, 2'd1, 2'd0, 1, 0);
    send_rsp(0, 32'h8899AABB, 1, 32'hFFFFFFAA);
    send_req(3'd2, 2'd2, 2'd1, 0, 0);
    send_rsp(0, 32'h8899AABB, 1, 32'h00008899);
    send_req(3'd4, 2'd0, 2'd2, 0, 0);
    send_rsp(0, 32'h8899AABB, 1, 32'h8899AABB);
    send_req(3'd7, 2'd3, 2'd0, 1, 0);
    send_rsp(0, 32'h8899AABB, 1, 32'hFFFFFF88);

    // Random formatting cases against the reference model
    for (int k = 0; k < 10; k++) begin
      send_req(3'(k), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), 0);
      send_rsp(0, $urandom, 0, 0);
    end

    // Kill with two loads outstanding; a new load during the wait completes
    send_req(3'd1, 2'd0, 2'd2, 0, 0);
    send_req(3'd2, 2'd0, 2'd2, 0, 1);
    pulse_kill();
    #1;
    check("kill_busy", busy, 1);
    send_rsp(1, 32'h12345678, 0, 0);
    send_req(3'd4, 2'd2, 2'd1, 1, 1);
    send_rsp(0, 32'h87654321, 0, 0);
    #1;
    check("kill_busy_mid", busy, 1);
    send_rsp(1, 32'hF00DCAFE, 0, 0);
    #1;
    check("kill_busy_end", busy, 0);

    // busy falls one cycle after the last killed response
    send_req(3'd2, 2'd0, 2'd2, 0, 0);
    pulse_kill();
    #1;
    check("kill1_busy_before", busy, 1);
    send_rsp(0, 32'hDEADBEEF, 0, 0);
    #1;
    check("kill1_busy_after", busy, 0);

    // Kill together with a response and a request
    send_req(3'd2, 2'd0, 2'd2, 0, 0);
    kill = 1'b1;
    req_valid = 1'b1; req_trans = 3'd7; req_off = 2'd0; req_size = 2'd2; req_sign = 1'b0;
    #1;
    check("kill_req_ready", req_ready, 0);
    send_rsp(0, 32'hABCDEF01, 0, 0);
    kill = 1'b0;
    req_valid = 1'b0;
    #1;
    check("kill_rsp_freed", busy, 0);
    check("kill_rsp_ready", req_ready, 1);

    // Reset mid-flight, then a stray response
    send_req(3'd3, 2'd0, 2'd2, 0, 0);
    send_req(3'd4, 2'd0, 2'd2, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin m_valid[i] = 0; m_kill[i] = 0; end
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 1);
    send_rsp(0, 32'h55555555, 0, 0);
    #1;
    check("stray_busy", busy, 0);
    check("stray_ready", req_ready, 1);
    check("stray_tag", req_tag, 0);
    send_req(3'd5, 2'd1, 2'd0, 1, 0);
    send_rsp(0, 32'h8899AABB, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
